imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Fetch sequencer for the 256 x 32 instruction memory (synchronous read, one-cycle latency). Owns the program counter, issues fetch addresses, presents each fetched word with its PC to decode, and handles decode back-pressure and zero-bubble branch redirects. It also gives a program loader exclusive write access to the memory while fetch is suspended. It sits between the instruction memory and the decode stage of the core.

## Interface
- ADDR_W, 8, instruction memory address width (PC width)
- DATA_W, 32, instruction word width
- START_PC, 0, PC loaded at reset and after every load session
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  decode not accepting; hold current instruction
- branch_valid  in  1  redirect fetch to branch_target this cycle
- branch_target  in  ADDR_W  redirect address
- load_req  in  1  loader requests memory / write strobe
- load_addr  in  ADDR_W  loader write address
- load_data  in  DATA_W  loader write data
- load_ack  out  1  write performed this cycle
- mem_addr  out  ADDR_W  instruction memory address
- mem_we  out  1  instruction memory write enable
- mem_wdata  out  DATA_W  instruction memory write data
- mem_rdata  in  DATA_W  instruction memory registered read data
- inst_out  out  DATA_W  instruction to decode (= mem_rdata)
- inst_pc  out  ADDR_W  address of inst_out
- inst_valid  out  1  inst_out valid

## Operation
- Registers: state {RUN, LOAD}, pc (next fetch address), rd_pc, rd_valid. inst_pc = rd_pc; inst_valid = rd_valid.
- Reset (reset_n low at an edge): state=RUN, pc=START_PC, rd_pc=START_PC, rd_valid=0. Outputs after reset: inst_valid=0, load_ack=0, mem_we=0, mem_addr=START_PC.
- RUN priority per cycle: load_req > branch_valid > stall > advance.
  - load_req=1: state<=LOAD, rd_valid<=0; no write this cycle; mem_addr=pc.
  - branch_valid=1 (overrides stall): mem_addr=branch_target; rd_pc<=branch_target, rd_valid<=1, pc<=branch_target+1. Instruction currently shown is discarded.
  - stall=1: mem_addr=rd_pc so the memory re-reads the displayed word; pc, rd_pc and rd_valid hold.
  - advance: mem_addr=pc; rd_pc<=pc, rd_valid<=1, pc<=pc+1.
- An instruction is consumed on a cycle with inst_valid=1 and stall=0.
- LOAD: each cycle with load_req=1 drives mem_addr=load_addr, mem_wdata=load_data, mem_we=1 and load_ack=1, all combinationally. stall and branch_valid are ignored. load_req=0 causes state<=RUN, pc<=START_PC, rd_valid<=0 (restart from START_PC).
- mem_we=0 and load_ack=0 in RUN. mem_wdata=load_data at all times.
- Arithmetic: pc and branch_target+1 wrap modulo 2^ADDR_W (255 -> 0).
- Memory requirement: write on the rising edge when mem_we=1. Read-during-write is never exercised by this block.

## Timing
- Fetch latency: one cycle from mem_addr to inst_out. The first inst_valid=1 (PC=START_PC) occurs in the second cycle after reset_n goes high.
- Steady state: one instruction per cycle with no stall.
- Branch: zero bubbles. The cycle after branch_valid shows inst_pc=branch_target with inst_valid=1.
- Stall: inst_out, inst_pc and inst_valid are stable for every stalled cycle. On release, the next instruction appears after one edge.
- Load entry: one dead cycle (RUN->LOAD, no write). Load exit: one dead cycle, then START_PC is fetched.
- Reset mid-LOAD or mid-stall: reset wins at that edge. Any partial load keeps the words already written.

## Configuration
- IMEM_FETCH_PERF_EN defined: adds outputs perf_consumed[15:0] (increments per consumed instruction), perf_stalls[15:0] (increments per cycle with inst_valid=1 and stall=1) and perf_redirects[15:0] (increments per accepted branch in RUN). All three saturate at 16'hFFFF, reset to 0, and are not cleared by LOAD.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, preload words 0..5 distinct, no stall -> inst_pc 0,1,2,3,4,5 on consecutive cycles, inst_valid rising exactly 2 cycles after reset_n high.
- stall high 3 cycles while inst_pc=2 -> inst_pc=2 and inst_out=mem[2] held 3 cycles; next cycle inst_pc=3.
- branch_valid with target 37 while stall=1 at inst_pc=10 -> next cycle inst_pc=37, then 38; instruction 10 never consumed.
- Let pc run through 255 -> inst_pc 254, 255, 0, 1 (wrap).
- load_req for 4 cycles writing addr 0..3 = 32'h7104_1000, 0, 0, 0 -> one dead cycle, then load_ack=1 and mem_we=1 for each write, no inst_valid during LOAD; after load_req drops, inst_pc=0 and inst_out=32'h7104_1000.
- With IMEM_FETCH_PERF_EN: 10 consumed, 3 stall cycles, 1 branch -> perf_consumed=10, perf_stalls=3, perf_redirects=1; force 70000 consumes -> perf_consumed=16'hFFFF.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: PC, zero-bubble redirects, decode back-pressure, loader write path.
// Optional IMEM_FETCH_PERF_EN adds saturating consumed/stall/redirect counters.
//
// state | meaning
// RUN   | fetching; one instruction per cycle unless stalled or redirected
// LOAD  | loader owns the memory; each load_req cycle is one write
module imem_fetch_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int START_PC = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [15:0]       perf_consumed,
  output logic [15:0]       perf_stalls,
  output logic [15:0]       perf_redirects
`endif
);

  typedef enum logic {RUN, LOAD} state_t;

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_PC);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
  logic              rd_valid_q, rd_valid_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pc_q       <= START;
      rd_pc_q    <= START;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rd_pc_q    <= rd_pc_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rd_pc_d    = rd_pc_q;
    rd_valid_d = rd_valid_q;
    mem_addr   = pc_q;
    mem_we     = 1'b0;
    load_ack   = 1'b0;
    case (state_q)
      RUN: begin
        if (load_req) begin
          state_d    = LOAD;
          rd_valid_d = 1'b0;
        end else if (branch_valid) begin
          mem_addr   = branch_target;
          rd_pc_d    = branch_target;
          rd_valid_d = 1'b1;
          pc_d       = branch_target + ONE;
        end else if (stall) begin
          // re-read the displayed word so inst_out stays put
          mem_addr = rd_pc_q;
        end else begin
          rd_pc_d    = pc_q;
          rd_valid_d = 1'b1;
          pc_d       = pc_q + ONE;
        end
      end
      LOAD: begin
        if (load_req) begin
          mem_addr = load_addr;
          mem_we   = 1'b1;
          load_ack = 1'b1;
        end else begin
          state_d    = RUN;
          pc_d       = START;
          rd_valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign mem_wdata  = load_data;
  assign inst_out   = mem_rdata;
  assign inst_pc    = rd_pc_q;
  assign inst_valid = rd_valid_q;

`ifdef IMEM_FETCH_PERF_EN
  logic ev_consume, ev_stall, ev_redirect;

  assign ev_consume  = rd_valid_q && !stall;
  assign ev_stall    = rd_valid_q && stall;
  assign ev_redirect = (state_q == RUN) && !load_req && branch_valid;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_consumed  <= 16'd0;
      perf_stalls    <= 16'd0;
      perf_redirects <= 16'd0;
    end else begin
      if (ev_consume && perf_consumed != 16'hFFFF)
        perf_consumed <= perf_consumed + 16'd1;
      if (ev_stall && perf_stalls != 16'hFFFF)
        perf_stalls <= perf_stalls + 16'd1;
      if (ev_redirect && perf_redirects != 16'hFFFF)
        perf_redirects <= perf_redirects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: vector table for fetch/stall/branch/wrap, hand sequences for load and reset,
// and a scoreboard of consumed instructions. Counter checks build only with IMEM_FETCH_PERF_EN.
module tb_imem_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall, branch_valid, load_req;
  logic [7:0]  branch_target, load_addr;
  logic [31:0] load_data;
  logic        load_ack, mem_we, inst_valid;
  logic [7:0]  mem_addr, inst_pc;
  logic [31:0] mem_wdata, mem_rdata, inst_out;
`ifdef IMEM_FETCH_PERF_EN
  logic [15:0] perf_consumed, perf_stalls, perf_redirects;
`endif

  imem_fetch_ctrl #(.ADDR_W(8), .DATA_W(32), .START_PC(0)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_ack(load_ack), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_valid(inst_valid)
`ifdef IMEM_FETCH_PERF_EN
    , .perf_consumed(perf_consumed), .perf_stalls(perf_stalls),
    .perf_redirects(perf_redirects)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] img(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0001_0103;
  endfunction

  logic        preload;
  logic [31:0] mem [256];
  logic [31:0] exp_img [256];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= img(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];
  logic sb_en;

  // every consumed instruction must match the next expected one, in order
  always @(negedge clock) begin
    if (sb_en && reset_n && inst_valid && !stall) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_consume", {24'd0, inst_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", {24'd0, inst_pc}, {24'd0, e.pc});
        check("sb_data", inst_out, e.data);
      end
    end
  end

  typedef struct {
    logic       stall;
    logic       branch;
    logic [7:0] target;
    logic [7:0] exp_addr;
    logic       exp_valid;
    logic [7:0] exp_pc;
  } vec_t;
  vec_t vecs[20];

  logic       cur_valid;
  logic [7:0] cur_pc;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'd0,   8'd1,   1'b1, 8'd1};
    vecs[2]  = '{1'b0, 1'b0, 8'd0,   8'd2,   1'b1, 8'd2};
    vecs[3]  = '{1'b0, 1'b0, 8'd0,   8'd3,   1'b1, 8'd3};
    vecs[4]  = '{1'b0, 1'b0, 8'd0,   8'd4,   1'b1, 8'd4};
    vecs[5]  = '{1'b0, 1'b0, 8'd0,   8'd5,   1'b1, 8'd5};
    vecs[6]  = '{1'b0, 1'b1, 8'd2,   8'd2,   1'b1, 8'd2};
    vecs[7]  = '{1'b1, 1'b0, 8'd0,   8'd2,   1'b1, 8'd2};
    vecs[8]  = '{1'b1, 1'b0, 8'd0,   8'd2,   1'b1, 8'd2};
    vecs[9]  = '{1'b1, 1'b0, 8'd0,   8'd2,   1'b1, 8'd2};
    vecs[10] = '{1'b0, 1'b0, 8'd0,   8'd3,   1'b1, 8'd3};
    vecs[11] = '{1'b0, 1'b1, 8'd10,  8'd10,  1'b1, 8'd10};
    vecs[12] = '{1'b1, 1'b1, 8'd37,  8'd37,  1'b1, 8'd37};
    vecs[13] = '{1'b0, 1'b0, 8'd0,   8'd38,  1'b1, 8'd38};
    vecs[14] = '{1'b0, 1'b1, 8'd254, 8'd254, 1'b1, 8'd254};
    vecs[15] = '{1'b0, 1'b0, 8'd0,   8'd255, 1'b1, 8'd255};
    vecs[16] = '{1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 8'd0};
    vecs[17] = '{1'b0, 1'b0, 8'd0,   8'd1,   1'b1, 8'd1};
    vecs[18] = '{1'b0, 1'b1, 8'd255, 8'd255, 1'b1, 8'd255};
    vecs[19] = '{1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 8'd0};

    for (int i = 0; i < 256; i++) exp_img[i] = img(i);
    sb_en = 1'b1;
    preload = 1'b1;
    reset_n = 1'b0;
    stall = 1'b0; branch_valid = 1'b0; branch_target = 8'd0;
    load_req = 1'b0; load_addr = 8'd0; load_data = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    preload = 1'b0;
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_load_ack", {31'd0, load_ack}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    reset_n = 1'b1;

    cur_valid = 1'b0;
    cur_pc = 8'd0;
    for (int i = 0; i < 20; i++) begin
      stall = vecs[i].stall;
      branch_valid = vecs[i].branch;
      branch_target = vecs[i].target;
      if (cur_valid && !vecs[i].stall) sb_q.push_back('{cur_pc, exp_img[cur_pc]});
      #1;
      check($sformatf("vec%0d_mem_addr", i), {24'd0, mem_addr}, {24'd0, vecs[i].exp_addr});
      check($sformatf("vec%0d_mem_we", i), {31'd0, mem_we}, 32'd0);
      @(posedge clock); #1;
      check($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), {24'd0, inst_pc}, {24'd0, vecs[i].exp_pc});
        check($sformatf("vec%0d_data", i), inst_out, exp_img[vecs[i].exp_pc]);
      end
      cur_valid = vecs[i].exp_valid;
      cur_pc = vecs[i].exp_pc;
    end

    // load session: one dead entry cycle, four writes, one dead exit cycle
    stall = 1'b0; branch_valid = 1'b0; load_req = 1'b1;
    sb_q.push_back('{cur_pc, exp_img[cur_pc]});
    #1;
    check("load_entry_ack", {31'd0, load_ack}, 32'd0);
    check("load_entry_we", {31'd0, mem_we}, 32'd0);
    check("load_entry_addr", {24'd0, mem_addr}, 32'd1);
    @(posedge clock); #1;
    check("load_entry_valid", {31'd0, inst_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      load_addr = 8'(k);
      load_data = (k == 0) ? 32'h7104_1000 : 32'd0;
      branch_valid = (k == 1);
      branch_target = 8'd99;
      stall = (k == 2);
      exp_img[k] = load_data;
      #1;
      check($sformatf("load%0d_ack", k), {31'd0, load_ack}, 32'd1);
      check($sformatf("load%0d_we", k), {31'd0, mem_we}, 32'd1);
      check($sformatf("load%0d_addr", k), {24'd0, mem_addr}, k);
      check($sformatf("load%0d_wdata", k), mem_wdata, load_data);
      @(posedge clock); #1;
      check($sformatf("load%0d_valid", k), {31'd0, inst_valid}, 32'd0);
    end
    load_req = 1'b0; branch_valid = 1'b0; stall = 1'b0;
    #1;
    check("load_exit_we", {31'd0, mem_we}, 32'd0);
    check("load_exit_ack", {31'd0, load_ack}, 32'd0);
    @(posedge clock); #1;
    check("load_exit_valid", {31'd0, inst_valid}, 32'd0);
    #1;
    check("restart_addr", {24'd0, mem_addr}, 32'd0);
    @(posedge clock); #1;
    check("restart_valid", {31'd0, inst_valid}, 32'd1);
    check("restart_pc", {24'd0, inst_pc}, 32'd0);
    check("restart_data", inst_out, 32'h7104_1000);
    sb_q.push_back('{8'd0, 32'h7104_1000});
    @(posedge clock); #1;
    check("restart_pc1", {24'd0, inst_pc}, 32'd1);
    check("restart_data1", inst_out, 32'd0);

    // reset in the middle of a load keeps the word already written
    sb_q.push_back('{8'd1, 32'd0});
    load_req = 1'b1;
    @(posedge clock); #1;
    load_addr = 8'd10; load_data = 32'hDEAD_BEEF; exp_img[10] = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("midload_rst_valid", {31'd0, inst_valid}, 32'd0);
    check("midload_rst_we", {31'd0, mem_we}, 32'd0);
    check("midload_rst_addr", {24'd0, mem_addr}, 32'd0);
    reset_n = 1'b1; load_req = 1'b0;
    @(posedge clock); #1;
    check("post_rst_pc", {24'd0, inst_pc}, 32'd0);
    check("post_rst_data", inst_out, 32'h7104_1000);
    sb_q.push_back('{8'd0, 32'h7104_1000});
    branch_valid = 1'b1; branch_target = 8'd10;
    @(posedge clock); #1;
    branch_valid = 1'b0; stall = 1'b1;
    check("kept_word_pc", {24'd0, inst_pc}, 32'd10);
    check("kept_word_data", inst_out, 32'hDEAD_BEEF);
    @(posedge clock); #1;
    check("sb_drained", sb_q.size(), 32'd0);
    sb_en = 1'b0;

`ifdef IMEM_FETCH_PERF_EN
    reset_n = 1'b0; stall = 1'b0; branch_valid = 1'b0; load_req = 1'b0;
    repeat (2) @(posedge clock); #1;
    check("perf_rst_consumed", {16'd0, perf_consumed}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1; stall = 1'b1;
    repeat (3) @(posedge clock);
    #1; stall = 1'b0; branch_valid = 1'b1; branch_target = 8'd50;
    @(posedge clock); #1;
    branch_valid = 1'b0; stall = 1'b1;
    check("perf_consumed", {16'd0, perf_consumed}, 32'd10);
    check("perf_stalls", {16'd0, perf_stalls}, 32'd3);
    check("perf_redirects", {16'd0, perf_redirects}, 32'd1);
    stall = 1'b0;
    repeat (70000) @(posedge clock);
    #1;
    check("perf_consumed_sat", {16'd0, perf_consumed}, 32'h0000_FFFF);
    check("perf_stalls_hold", {16'd0, perf_stalls}, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
